source_check: RTL
=================

# source_check

Receive-side pattern checker for the 16-bit FMCA test-source bus. It sits at the far end of the link driven by `source_gen`, running on the 1280 MHz clock. It compares each incoming word against the pattern selected by `sel`: counter, PRBS-15, constant or inverted constant. It acquires lock, counts errors and reports lock and mode on the indicator outputs.

## Interface
- `CONST_VAL`, 16'h5555, pattern expected for the const source; const_bar expects ~CONST_VAL.
- `LOCK_CNT`, 8, consecutive matching words required to declare lock (1..255).
- `LOSS_CNT`, 4, consecutive mismatching words in LOCKED that drop lock (1..255).
- `clk1280` input 1: sole clock; all logic on its rising edge.
- `FPGA_RESETn` input 1: asynchronous, active-low reset.
- `din` input 16: received source word, one per cycle.
- `sel` input 2: expected mode. 00 = counter, 01 = PRBS, 10 = const, 11 = const_bar.
- `clear` input 1: synchronous, single-cycle; zeroes `err_cnt`.
- `locked` output 1: checker in LOCKED state.
- `err_flag` output 1: one-cycle pulse per errored word while locked.
- `err_cnt` output 32: saturating error counter.
- `indic` output 2: `{locked, err_seen}`. `err_seen` is sticky, set by any error, cleared by `clear` or reset.

## Operation
- Input stage: `din` is registered as `d1`, then the previous word as `d2`.
- Prediction, counter mode: expected = prev + 1, modulo 2^16, so 16'hFFFF is followed by 16'h0000.
- Prediction, PRBS mode: serial sequence s[n] = s[n-14] XOR s[n-15]. Each word carries 16 consecutive bits with `din[15]` earliest. The next word is computed from the last 15 bits of prev.
- Prediction, const/const_bar modes: expected is fixed at CONST_VAL or ~CONST_VAL.
- Source of prev: in HUNT and SYNC, prev = `d2`, the received word (self-synchronising). In LOCKED, prev = the checker's own previous expected word, so one corrupted word counts as exactly one error and does not propagate.
- States: HUNT → SYNC → LOCKED.
  - HUNT: on a match, go to SYNC with match count = 1.
  - SYNC: on a match, count++. When count = LOCK_CNT, go to LOCKED. On a mismatch, go to HUNT.
  - LOCKED: on a mismatch, err_cnt += increment, pulse `err_flag`, set `err_seen`, loss count++. On a match, loss count = 0. When loss count reaches LOSS_CNT, go to HUNT.
- A change of `sel`, detected against the registered `sel`, forces HUNT with all counters except `err_cnt` cleared.
- Errors are counted only in LOCKED. `err_cnt` saturates at 32'hFFFFFFFF.
- If `clear` and an error occur in the same cycle, `clear` wins: `err_cnt` = 0 and `err_seen` = 0, but `err_flag` still pulses.
- Reset values: state HUNT, `locked` 0, `err_flag` 0, `err_cnt` 0, `indic` 2'b00, all pipeline registers 0.
- Reset asserted mid-operation returns all outputs to reset values immediately, without waiting for a clock edge.

## Timing
- Latency from `din` to compare is 1 cycle. `err_flag` and `err_cnt` update 2 cycles after the errored word is presented on `din`.
- Self-synchronising modes (counter, PRBS): `locked` rises LOCK_CNT+3 cycles after the first clean word is presented on `din`.
- Fixed modes (const, const_bar): `locked` rises LOCK_CNT+2 cycles after the first clean word is presented on `din`.
- `locked` falls on the cycle the LOSS_CNT-th consecutive error is counted.
- After a `sel` change, checking restarts from HUNT on the next cycle.
- No handshake; `din` is assumed valid every cycle.

## Configuration
- `SOURCE_CHECK_BITCNT_EN`: when defined, the `err_cnt` increment is the popcount of (`din` XOR expected), i.e. a bit-error count, through a registered popcount stage. This adds one cycle to `err_flag`/`err_cnt` latency only.
- When undefined, the increment is 1 per errored word (word-error count).
- Saturation behaviour is identical in both builds.

## Test plan
- Counter mode, `din` counting from 16'hFFF0: `locked` = 1 at LOCK_CNT+3 cycles, and stays locked across the 16'hFFFF→16'h0000 wrap with `err_cnt` = 0.
- PRBS mode, locked, one word with bit 3 flipped: `err_flag` pulses once and `err_cnt` = 1 in both builds (a single bit flip gives popcount 1). Following words are clean and `locked` stays 1.
- PRBS mode, locked, one word with 5 bits flipped: `err_cnt` = 1 without the macro, `err_cnt` = 5 with `SOURCE_CHECK_BITCNT_EN`.
- `sel` = 10 while `din` = ~CONST_VAL: `locked` is never set and `err_cnt` stays 0. Switching `sel` to 11 gives `locked` = 1 after LOCK_CNT+2 cycles.
- Locked in const mode, LOSS_CNT consecutive bad words: `err_cnt` = LOSS_CNT, then `locked` → 0 and the checker relocks once clean data resumes.
- `FPGA_RESETn` pulsed low mid-lock, asynchronous to the clock: all outputs are 0 before the next edge. Drive `clear` together with an error: `err_cnt` = 0 and `err_flag` = 1.

Source files
------------

// File: rtl/source_check_if.sv
// source_check_if: bundles the receive-side test-source bus and the checker's
// status outputs. master = the stimulus/observer side, slave = the checker.
// Signals: din/sel/clear toward the checker; locked/err_flag/err_cnt/indic back.
interface source_check_if;
  logic [15:0] din;
  logic [1:0]  sel;
  logic        clear;
  logic        locked;
  logic        err_flag;
  logic [31:0] err_cnt;
  logic [1:0]  indic;

  modport master (
    output din, sel, clear,
    input  locked, err_flag, err_cnt, indic
  );

  modport slave (
    input  din, sel, clear,
    output locked, err_flag, err_cnt, indic
  );
endinterface

// File: rtl/source_check.sv
// source_check: receive-side checker for the 16-bit test-source bus
// (counter / PRBS-15 / const / const_bar), with lock acquisition and error counting.
// Latency: din->compare 1 cycle; err_flag/err_cnt 2 cycles (3 with SOURCE_CHECK_BITCNT_EN).
// Backpressure: none, din is taken every cycle.
// Ports: clk1280 (sole clock), FPGA_RESETn (async, active-low), bus (source_check_if.slave):
//   din, sel (00 cnt, 01 prbs, 10 const, 11 const_bar), clear -> locked, err_flag, err_cnt, indic.
// Build option: define SOURCE_CHECK_BITCNT_EN to count bit errors (popcount) instead of words.
module source_check #(
  parameter logic [15:0] CONST_VAL = 16'h5555,
  parameter int          LOCK_CNT  = 8,
  parameter int          LOSS_CNT  = 4
) (
  input  logic          clk1280,
  input  logic          FPGA_RESETn,
  source_check_if.slave bus
);

  localparam logic [7:0] LOCK_N    = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_CNT - 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [15:0] d1, d2;
  logic [15:0] exp_q;       // expected word used for the previous compare
  logic [15:0] prev;
  logic [15:0] exp_word;
  logic [1:0]  sel_q;
  logic [7:0]  match_cnt, match_cnt_nxt;
  logic [7:0]  loss_cnt, loss_cnt_nxt;
  logic        sel_chg;
  logic        match;
  logic        err_now;
  logic        err_hit;
  logic [31:0] err_inc;
  logic [32:0] err_sum;
  logic [31:0] err_cnt_q;
  logic        err_flag_q;
  logic        err_seen;

  // PRBS-15 (s[n] = s[n-14] ^ s[n-15]), 16 serial bits per word, bit 15 first.
  // h[i] holds s[k+i] where prev word bit 15 is s[k]; only s[k+1..k+15] feed
  // the next word, so the MSB of prev is not needed.
  function automatic logic [15:0] prbs_next(input logic [14:0] p);
    logic [31:1] h;
    logic [15:0] n;
    for (int i = 1; i < 16; i++) h[i] = p[15-i];
    for (int j = 0; j < 16; j++) begin
      h[16+j] = h[j+2] ^ h[j+1];
      n[15-j] = h[16+j];
    end
    return n;
  endfunction

  assign sel_chg = (bus.sel != sel_q);

  // While hunting/syncing the prediction is seeded from the received stream;
  // once locked it runs from its own history so one bad word is one error.
  always_comb begin
    prev = (state == LOCKED) ? exp_q : d2;
    case (sel_q)
      2'b00:   exp_word = prev + 16'd1;
      2'b01:   exp_word = prbs_next(prev[14:0]);
      2'b10:   exp_word = CONST_VAL;
      default: exp_word = ~CONST_VAL;
    endcase
  end

  assign match = (d1 == exp_word);

  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    loss_cnt_nxt  = loss_cnt;
    err_now       = 1'b0;
    if (sel_chg) begin
      state_nxt     = HUNT;
      match_cnt_nxt = 8'd0;
      loss_cnt_nxt  = 8'd0;
    end else begin
      case (state)
        HUNT: begin
          if (match) begin
            state_nxt     = SYNC;
            match_cnt_nxt = 8'd1;
          end
        end
        SYNC: begin
          // count is registered, so lock is declared the cycle after the
          // LOCK_CNT-th consecutive match has been recorded
          if (match_cnt == LOCK_N) begin
            state_nxt     = LOCKED;
            match_cnt_nxt = 8'd0;
            loss_cnt_nxt  = 8'd0;
          end else if (match) begin
            match_cnt_nxt = match_cnt + 8'd1;
          end else begin
            state_nxt     = HUNT;
            match_cnt_nxt = 8'd0;
          end
        end
        LOCKED: begin
          if (!match) begin
            err_now = 1'b1;
            if (loss_cnt == LOSS_LAST) begin
              state_nxt    = HUNT;
              loss_cnt_nxt = 8'd0;
            end else begin
              loss_cnt_nxt = loss_cnt + 8'd1;
            end
          end else begin
            loss_cnt_nxt = 8'd0;
          end
        end
        default: begin
          state_nxt     = HUNT;
          match_cnt_nxt = 8'd0;
          loss_cnt_nxt  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk1280 or negedge FPGA_RESETn) begin
    if (!FPGA_RESETn) begin
      state     <= HUNT;
      d1        <= 16'd0;
      d2        <= 16'd0;
      exp_q     <= 16'd0;
      sel_q     <= 2'b00;
      match_cnt <= 8'd0;
      loss_cnt  <= 8'd0;
    end else begin
      state     <= state_nxt;
      d1        <= bus.din;
      d2        <= d1;
      exp_q     <= exp_word;
      sel_q     <= bus.sel;
      match_cnt <= match_cnt_nxt;
      loss_cnt  <= loss_cnt_nxt;
    end
  end

`ifdef SOURCE_CHECK_BITCNT_EN
  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  logic       err_p;
  logic [4:0] pop_p;

  always_ff @(posedge clk1280 or negedge FPGA_RESETn) begin
    if (!FPGA_RESETn) begin
      err_p <= 1'b0;
      pop_p <= 5'd0;
    end else begin
      err_p <= err_now;
      pop_p <= err_now ? popcnt16(d1 ^ exp_word) : 5'd0;
    end
  end

  assign err_hit = err_p;
  assign err_inc = {27'd0, pop_p};
`else
  assign err_hit = err_now;
  assign err_inc = 32'd1;
`endif

  assign err_sum = {1'b0, err_cnt_q} + {1'b0, err_inc};

  // clear beats a coincident error for the count and sticky bit, but the
  // error pulse is still reported
  always_ff @(posedge clk1280 or negedge FPGA_RESETn) begin
    if (!FPGA_RESETn) begin
      err_cnt_q  <= 32'd0;
      err_flag_q <= 1'b0;
      err_seen   <= 1'b0;
    end else begin
      err_flag_q <= err_hit;
      if (bus.clear) begin
        err_cnt_q <= 32'd0;
        err_seen  <= 1'b0;
      end else if (err_hit) begin
        err_cnt_q <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
        err_seen  <= 1'b1;
      end
    end
  end

  assign bus.locked   = (state == LOCKED);
  assign bus.err_flag = err_flag_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.indic    = {bus.locked, err_seen};

endmodule
